// File: rtl/trap_pkg.sv
// Shared trap sequencer types: FSM states, request kinds, exception codes, interrupt indices.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTER    = 2'd1,
    WAIT     = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    K_EXC = 2'd0,
    K_IRQ = 2'd1,
    K_RET = 2'd2
  } kind_e;

  localparam logic [4:0] ILLEGAL_INSN = 5'd2;

  localparam logic [4:0] MSI = 5'd3;
  localparam logic [4:0] MTI = 5'd7;
  localparam logic [4:0] MEI = 5'd11;

  function automatic logic [31:0] irq_cause(input logic [4:0] idx);
    return {1'b1, 26'b0, idx};
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Interrupt index selection: MEI, then MSI, then MTI, then the lowest other pending line.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic [31:0] ip,
  output logic [4:0]  idx,
  output logic        valid
);

  always_comb begin
    idx   = 5'd0;
    valid = |ip;
    // Descending scan so the lowest ordinary line is the last one written.
    for (int i = 31; i >= 0; i--) begin
      if (ip[i] && (i != 3) && (i != 7) && (i != 11)) idx = 5'(i);
    end
    if (ip[MTI]) idx = MTI;
    if (ip[MSI]) idx = MSI;
    if (ip[MEI]) idx = MEI;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / MRET sequencer: picks one request at an instruction boundary, commands the
// CSR unit, holds the pipeline for the save/restore latency, then issues one PC reload.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ip,
  input  logic [1:0]  cpm,
  input  logic        mie_global,
  input  logic        illegal_address,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        mret_req,
  input  logic        insn_boundary,
  output logic [31:0] cause,
  output logic        exeption,
  output logic        interrupt,
  output logic        trap_return,
  output logic        stall,
  output logic        redirect
);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cause_q, cause_d;

  logic [4:0]  irq_idx;
  logic        irq_pend;
  logic        irq_ok;

  trap_prio_enc u_prio (
    .ip    (ip),
    .idx   (irq_idx),
    .valid (irq_pend)
  );

  // Machine-mode interrupts are masked by MIE only while running in M-mode.
  assign irq_ok = irq_pend && (mie_global || (cpm != 2'b11));

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    exeption    = 1'b0;
    interrupt   = 1'b0;
    trap_return = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;

    case (state_q)
      IDLE: begin
        if (insn_boundary) begin
          if (illegal_address) begin
            cause_d = {27'b0, ILLEGAL_INSN};
            kind_d  = K_EXC;
            state_d = ENTER;
          end else if (exc_req) begin
            cause_d = {27'b0, exc_code};
            kind_d  = K_EXC;
            state_d = ENTER;
          end else if (irq_ok) begin
            cause_d = irq_cause(irq_idx);
            kind_d  = K_IRQ;
            state_d = ENTER;
          end else if (mret_req) begin
            kind_d  = K_RET;
            state_d = ENTER;
          end
        end
      end
      ENTER: begin
        stall       = 1'b1;
        exeption    = (kind_q != K_RET);
        interrupt   = (kind_q == K_IRQ);
        trap_return = (kind_q == K_RET);
        if (LATENCY <= 1) begin
          state_d = REDIRECT;
        end else begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        stall    = 1'b1;
        redirect = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= K_EXC;
      cnt_q   <= 4'd0;
      cause_q <= 32'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign cause = cause_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: one LATENCY=2 and one LATENCY=1 instance on shared stimulus.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ip;
  logic [1:0]  cpm;
  logic        mie_global;
  logic        illegal_address;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        mret_req;
  logic        insn_boundary;

  logic [31:0] cause2, cause1;
  logic        exc2, irq2, ret2, stall2, redir2;
  logic        exc1, irq1, ret1, stall1, redir1;

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  trap_sequencer #(.LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .ip(ip), .cpm(cpm), .mie_global(mie_global),
    .illegal_address(illegal_address), .exc_req(exc_req), .exc_code(exc_code),
    .mret_req(mret_req), .insn_boundary(insn_boundary),
    .cause(cause2), .exeption(exc2), .interrupt(irq2), .trap_return(ret2),
    .stall(stall2), .redirect(redir2)
  );

  trap_sequencer #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .ip(ip), .cpm(cpm), .mie_global(mie_global),
    .illegal_address(illegal_address), .exc_req(exc_req), .exc_code(exc_code),
    .mret_req(mret_req), .insn_boundary(insn_boundary),
    .cause(cause1), .exeption(exc1), .interrupt(irq1), .trap_return(ret1),
    .stall(stall1), .redirect(redir1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ip = 32'h0; illegal_address = 1'b0; exc_req = 1'b0; exc_code = 5'd0;
    mret_req = 1'b0; insn_boundary = 1'b0;
  endtask

  // Interrupt sequence on the LATENCY=2 instance; checks cause at ENTER and drains to IDLE.
  task automatic run_irq(input string tag, input logic [31:0] pend, input logic [31:0] exp_cause);
    ip = pend; mie_global = 1'b1; cpm = 2'b11; insn_boundary = 1'b1;
    step();
    chk(tag, cause2, exp_cause);
    clr();
    step(); step(); step();
  endtask

  initial begin
    clr();
    cpm = 2'b11; mie_global = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_cause", cause2, 32'h0);
    chk("rst_outs", {27'b0, exc2, irq2, ret2, stall2, redir2}, 32'h0);
    rst = 1'b0;

    // No instruction boundary: request is not sampled.
    ip = 32'h880; mie_global = 1'b1; insn_boundary = 1'b0;
    step();
    chk("noboundary_stall", {31'b0, stall2}, 32'h0);

    // MEI wins over MTI; redirect two cycles after ENTER with LATENCY=2.
    insn_boundary = 1'b1;
    step();
    chk("irq_cause", cause2, 32'h8000000B);
    chk("irq_enter", {29'b0, exc2, irq2, stall2}, 32'h7);
    clr();
    step();
    chk("irq_wait", {28'b0, exc2, irq2, stall2, redir2}, 32'h2);
    step();
    chk("irq_redir", {30'b0, stall2, redir2}, 32'h3);
    step();
    chk("irq_idle", {30'b0, stall2, redir2}, 32'h0);

    // Exception beats a simultaneous interrupt.
    exc_req = 1'b1; exc_code = 5'd5; ip = 32'h8; insn_boundary = 1'b1;
    step();
    chk("exc_cause", cause2, 32'h5);
    chk("exc_flags", {30'b0, exc2, irq2}, 32'h2);
    clr();
    step(); step(); step();

    // MRET: trap_return only, cause held, redirect at ENTER+LATENCY.
    mret_req = 1'b1; insn_boundary = 1'b1;
    step();
    chk("mret_enter", {29'b0, exc2, irq2, ret2}, 32'h1);
    chk("mret_cause", cause2, 32'h5);
    clr();
    step();
    chk("mret_wait", {30'b0, ret2, redir2}, 32'h0);
    step();
    chk("mret_redir", {31'b0, redir2}, 32'h1);
    step();

    // Masked in M-mode with MIE=0, taken from U-mode.
    ip = 32'h80; mie_global = 1'b0; cpm = 2'b11; insn_boundary = 1'b1;
    step();
    chk("masked_stall", {30'b0, stall2, exc2}, 32'h0);
    cpm = 2'b00;
    step();
    chk("umode_cause", cause2, 32'h80000007);
    chk("umode_irq", {31'b0, irq2}, 32'h1);
    clr();
    step(); step(); step();

    run_irq("prio_msi", 32'h88, 32'h80000003);
    run_irq("prio_low", 32'h30, 32'h80000004);
    run_irq("prio_hi",  32'h80000000, 32'h8000001F);

    // Reset during WAIT aborts the sequence with no redirect pulse.
    exc_req = 1'b1; exc_code = 5'd4; insn_boundary = 1'b1;
    step();
    clr();
    step();
    chk("abort_inwait", {30'b0, stall2, redir2}, 32'h2);
    rst = 1'b1;
    step();
    chk("abort_stall", {30'b0, stall2, redir2}, 32'h0);
    chk("abort_cause", cause2, 32'h0);
    rst = 1'b0;
    step();
    chk("abort_noredir", {30'b0, stall2, redir2}, 32'h0);

    // LATENCY=1: illegal address beats exc_req, ENTER then REDIRECT back to back.
    illegal_address = 1'b1; exc_req = 1'b1; exc_code = 5'd5; insn_boundary = 1'b1;
    step();
    chk("l1_cause", cause1, 32'h2);
    chk("l1_enter", {29'b0, exc1, stall1, redir1}, 32'h6);
    clr();
    step();
    chk("l1_redir", {29'b0, exc1, stall1, redir1}, 32'h3);
    step();
    chk("l1_idle", {30'b0, stall1, redir1}, 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL take parameter: LATENCY, 2, cycles the CSR unit needs to save or restore trap state (legal range 1..15).
REQ-002 SHALL have port: clk  in  1  single core clock.
REQ-003 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port: ip  in  32  pending-and-enabled interrupt lines from the CSR unit.
REQ-005 SHALL have port: cpm  in  2  current privilege mode from the CSR unit.
REQ-006 SHALL have port: mie_global  in  1  mstatus.MIE.
REQ-007 SHALL have port: illegal_address  in  1  CSR access to an unimplemented address.
REQ-008 SHALL have port: exc_req, exc_code  in  1, 5  synchronous exception request and its code.
REQ-009 SHALL have port: mret_req  in  1  MRET executed.
REQ-010 SHALL have port: insn_boundary  in  1  current instruction retired; safe trap point.
REQ-011 SHALL have port: cause  out  32  trap cause to the CSR unit.
REQ-012 SHALL have port: exeption, interrupt, trap_return  out  1 each  single-cycle commands to the CSR unit.
REQ-013 SHALL have port: stall, redirect  out  1 each  hold pipeline; one-cycle PC reload (mtvec/mepc).

Function
REQ-014 SHALL implement FSM states IDLE, ENTER, WAIT, REDIRECT.
REQ-015 IDLE SHALL sample requests only when insn_boundary=1; otherwise it SHALL remain in IDLE with all outputs 0.
REQ-016 Request priority SHALL be: illegal_address (cause code 2) > exc_req > interrupt > mret_req.
REQ-017 An interrupt SHALL qualify when ip!=0 and (mie_global=1 or cpm!=2'b11).
REQ-018 The interrupt index SHALL be selected in the order 11, 3, 7, then the lowest set bit among the remaining bits.
REQ-019 cause SHALL be {1'b1,26'b0,idx} for an interrupt, {27'b0,code} for an exception, and held unchanged for MRET.
REQ-020 cause SHALL be registered on the IDLE->ENTER transition and held until the return to IDLE.
REQ-021 ENTER SHALL last exactly one cycle and assert exeption=1, plus interrupt=1 for interrupts; for MRET it SHALL assert trap_return=1 only.
REQ-022 WAIT SHALL last LATENCY-1 cycles using a 4-bit down-counter; with LATENCY=1 the FSM SHALL go ENTER->REDIRECT directly.
REQ-023 REDIRECT SHALL assert redirect=1 for exactly one cycle, then return to IDLE.
REQ-024 stall SHALL be 1 in ENTER, WAIT and REDIRECT, and 0 in IDLE.
REQ-025 Total latency from the sampling edge to the return to IDLE SHALL be LATENCY+1 cycles.
REQ-026 Requests arriving while not in IDLE SHALL be ignored; the requester holds them.
REQ-027 ip deasserting after ENTER SHALL NOT abort the sequence.
REQ-028 Simultaneous requests SHALL be resolved by REQ-016; losers are not queued.
REQ-029 No output SHALL be asserted in two consecutive trap sequences without one intervening IDLE cycle.

Reset
REQ-030 On rst=1 at a clk edge, the block SHALL enter IDLE on that edge, clear the counter, and drive cause=0 and all 1-bit outputs 0.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence without a redirect pulse.

Structure
REQ-032 A shared package trap_pkg SHALL hold the state enum, exception codes (ILLEGAL_INSN=2) and interrupt indices (MSI=3, MTI=7, MEI=11).
REQ-033 The interrupt priority selection SHALL be a combinational sub-module trap_prio_enc (ip in, idx and valid out).

Verification
REQ-034 The bench SHALL cover: ip=0x880, mie_global=1, insn_boundary=1 -> ENTER with cause=0x8000000B, interrupt=1, exeption=1; redirect 2 cycles later (LATENCY=2).
REQ-035 The bench SHALL cover: exc_req=1, exc_code=5 and ip=0x8 in the same cycle -> cause=0x00000005, interrupt=0.
REQ-036 The bench SHALL cover: mret_req=1 alone -> trap_return=1 for one cycle, exeption=0, redirect at ENTER+LATENCY cycles.
REQ-037 The bench SHALL cover: ip=0x80, mie_global=0, cpm=3 -> stays IDLE, stall=0; with cpm=0 -> cause=0x80000007.
REQ-038 The bench SHALL cover: rst=1 during WAIT -> next cycle IDLE, stall=0, cause=0, no redirect pulse.
REQ-039 The bench SHALL cover: LATENCY=1 with illegal_address=1 -> ENTER then REDIRECT on consecutive cycles, cause=0x00000002.
